// File: rtl/enemy_fleet_ctrl.sv
// enemy_fleet_ctrl
//   Fleet-level march controller. It runs once per video frame and decides
//   when the whole alien fleet takes a horizontal step and which way it goes.
//   When the next step would cross a screen edge, the fleet drops DROP_ROWS
//   pixels, one pixel per frame, and then reverses direction. The controller
//   also tracks the fleet bounding box and reports landing and wave-clear.
//
//   Ports
//     frame_clk          in   1   frame-rate clock (one rising edge per frame)
//     Reset              in   1   synchronous, active-high, beats every input
//     start              in   1   begin a wave; only looked at in IDLE
//     freeze             in   1   pause: every register holds, strobes are 0
//     alive_count        in   6   number of aliens still alive
//     enemy_direction_X  out  1   0 = left, 1 = right
//     enemy_direction_Y  out  1   1 = descend 1 px this frame
//     move_en            out  1   1-frame strobe: horizontal step this frame
//     fleet_x            out  10  bounding-box left x
//     fleet_y            out  10  bounding-box top y
//     fleet_landed       out  1   sticky: fleet bottom reached LAND_Y
//     wave_clear         out  1   1-frame strobe: alive_count reached 0
//     o_dbg_state        out  2   current FSM state (IDLE/MARCH/DESCEND/LANDED)
//
//   Every output is a register, so a decision made on one clock edge is
//   visible to the sprite instances for the whole following frame.
module enemy_fleet_ctrl #(
  parameter int INIT_X      = 100,
  parameter int INIT_Y      = 40,
  parameter int FLEET_W     = 300,
  parameter int FLEET_H     = 120,
  parameter int LEFT_BOUND  = 8,
  parameter int RIGHT_BOUND = 632,
  parameter int STEP_X      = 4,
  parameter int DROP_ROWS   = 8,
  parameter int LAND_Y      = 440,
  parameter int MIN_PERIOD  = 2
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       freeze,
  input  logic [5:0] alive_count,
  output logic       enemy_direction_X,
  output logic       enemy_direction_Y,
  output logic       move_en,
  output logic [9:0] fleet_x,
  output logic [9:0] fleet_y,
  output logic       fleet_landed,
  output logic       wave_clear,
  output logic [1:0] o_dbg_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MARCH   = 2'd1;
  localparam logic [1:0] S_DESCEND = 2'd2;
  localparam logic [1:0] S_LANDED  = 2'd3;

  logic [1:0] r_state;
  logic       r_dir_x;
  logic       r_dir_y;
  logic       r_move_en;
  logic [9:0] r_fleet_x;
  logic [9:0] r_fleet_y;
  logic       r_landed;
  logic       r_wave_clear;
  logic [6:0] r_frame_cnt;
  logic [3:0] r_drop_cnt;

  logic [6:0]  w_period_m1;
  logic        w_tick;
  logic [10:0] w_right_sum;
  logic        w_right_edge;
  logic        w_left_edge;
  logic [10:0] w_land_sum;
  logic        w_land;
  logic        w_drop_done;

  // period - 1 = MIN_PERIOD - 1 + alive_count; re-evaluated every frame, so a
  // shrinking period that leaves frame_cnt above it simply ticks right away.
  assign w_period_m1  = {1'b0, alive_count} + 7'(MIN_PERIOD - 1);
  assign w_tick       = (r_frame_cnt >= w_period_m1);

  // 11-bit sums so the edge and landing compares can never wrap.
  assign w_right_sum  = {1'b0, r_fleet_x} + 11'(FLEET_W + STEP_X);
  assign w_right_edge = r_dir_x && (w_right_sum > 11'(RIGHT_BOUND));
  assign w_left_edge  = !r_dir_x && ({1'b0, r_fleet_x} < 11'(LEFT_BOUND + STEP_X));

  // Looks at the y this frame's descent is about to produce (fleet_y + 1).
  assign w_land_sum   = {1'b0, r_fleet_y} + 11'(FLEET_H + 1);
  assign w_land       = (w_land_sum >= 11'(LAND_Y));
  assign w_drop_done  = (r_drop_cnt == 4'(DROP_ROWS - 1));

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_dir_x      <= 1'b1;
      r_dir_y      <= 1'b0;
      r_move_en    <= 1'b0;
      r_fleet_x    <= 10'(INIT_X);
      r_fleet_y    <= 10'(INIT_Y);
      r_landed     <= 1'b0;
      r_wave_clear <= 1'b0;
      r_frame_cnt  <= 7'd0;
      r_drop_cnt   <= 4'd0;
    end else if (freeze) begin
      // Hold everything; only the per-frame strobes are forced low.
      r_move_en    <= 1'b0;
      r_dir_y      <= 1'b0;
      r_wave_clear <= 1'b0;
    end else begin
      r_move_en    <= 1'b0;
      r_dir_y      <= 1'b0;
      r_wave_clear <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_fleet_x   <= 10'(INIT_X);
            r_fleet_y   <= 10'(INIT_Y);
            r_dir_x     <= 1'b1;
            r_frame_cnt <= 7'd0;
            r_state     <= S_MARCH;
          end
        end
        S_MARCH: begin
          if (alive_count == 6'd0) begin
            r_wave_clear <= 1'b1;
            r_state      <= S_IDLE;
          end else if (!w_tick) begin
            r_frame_cnt <= r_frame_cnt + 7'd1;
          end else begin
            r_frame_cnt <= 7'd0;
            if (w_right_edge || w_left_edge) begin
              r_drop_cnt <= 4'd0;
              r_state    <= S_DESCEND;
            end else begin
              r_move_en <= 1'b1;
              if (r_dir_x) r_fleet_x <= r_fleet_x + 10'(STEP_X);
              else         r_fleet_x <= r_fleet_x - 10'(STEP_X);
            end
          end
        end
        S_DESCEND: begin
          r_dir_y    <= 1'b1;
          r_fleet_y  <= r_fleet_y + 10'd1;
          r_drop_cnt <= r_drop_cnt + 4'd1;
          // Landing wins over the end of the drop.
          if (w_land) begin
            r_landed <= 1'b1;
            r_state  <= S_LANDED;
          end else if (w_drop_done) begin
            r_dir_x     <= !r_dir_x;
            r_frame_cnt <= 7'd0;
            r_state     <= S_MARCH;
          end
        end
        default: begin
          // LANDED: terminal until Reset; strobes already defaulted low.
          r_state <= S_LANDED;
        end
      endcase
    end
  end

  assign enemy_direction_X = r_dir_x;
  assign enemy_direction_Y = r_dir_y;
  assign move_en           = r_move_en;
  assign fleet_x           = r_fleet_x;
  assign fleet_y           = r_fleet_y;
  assign fleet_landed      = r_landed;
  assign wave_clear        = r_wave_clear;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_enemy_fleet_ctrl.sv
// tb_enemy_fleet_ctrl
//   Directed bench for enemy_fleet_ctrl. Inputs are driven and outputs are
//   sampled 1 time unit after each rising frame_clk edge. Expected values are
//   worked out by hand from the default parameters (period = 2 + alive_count,
//   right edge when x + 304 > 632, left edge when x < 12, landing when the
//   new y reaches 320).
module tb_enemy_fleet_ctrl;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MARCH   = 2'd1;
  localparam logic [1:0] S_DESCEND = 2'd2;
  localparam logic [1:0] S_LANDED  = 2'd3;

  // clock / reset
  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       start;
  logic       freeze;
  logic [5:0] alive_count;
  logic       enemy_direction_X;
  logic       enemy_direction_Y;
  logic       move_en;
  logic [9:0] fleet_x;
  logic [9:0] fleet_y;
  logic       fleet_landed;
  logic       wave_clear;
  logic [1:0] o_dbg_state;

  always #5 frame_clk = ~frame_clk;

  enemy_fleet_ctrl dut (
    .frame_clk         (frame_clk),
    .Reset             (Reset),
    .start             (start),
    .freeze            (freeze),
    .alive_count       (alive_count),
    .enemy_direction_X (enemy_direction_X),
    .enemy_direction_Y (enemy_direction_Y),
    .move_en           (move_en),
    .fleet_x           (fleet_x),
    .fleet_y           (fleet_y),
    .fleet_landed      (fleet_landed),
    .wave_clear        (wave_clear),
    .o_dbg_state       (o_dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int mv_cnt   = 0;
  int dy_cnt   = 0;
  int wc_cnt   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // One frame: advance past the edge, then tally the strobes seen.
  task automatic tick();
    @(posedge frame_clk);
    #1;
    if (move_en)           mv_cnt++;
    if (enemy_direction_Y) dy_cnt++;
    if (wave_clear)        wc_cnt++;
  endtask

  task automatic wait_move(input string tag, input int budget, output int n);
    bit hit = 0;
    n = 0;
    while (!hit && n < budget) begin
      tick();
      n++;
      if (move_en) hit = 1;
    end
    if (!hit) check_val({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] s, input int budget, output int n);
    n = 0;
    while (o_dbg_state !== s && n < budget) begin
      tick();
      n++;
    end
    if (o_dbg_state !== s) check_val({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_x(input string tag, input logic [9:0] x, input int budget);
    int n = 0;
    while (fleet_x !== x && n < budget) begin
      tick();
      n++;
    end
    check_val({tag, "_reached"}, 32'(fleet_x), 32'(x));
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_state"}, 32'(o_dbg_state), 32'(S_IDLE));
    check_val({tag, "_dirx"},  32'(enemy_direction_X), 1);
    check_val({tag, "_diry"},  32'(enemy_direction_Y), 0);
    check_val({tag, "_move"},  32'(move_en), 0);
    check_val({tag, "_x"},     32'(fleet_x), 100);
    check_val({tag, "_y"},     32'(fleet_y), 40);
    check_val({tag, "_landed"},32'(fleet_landed), 0);
    check_val({tag, "_wclr"},  32'(wave_clear), 0);
  endtask

  task automatic start_wave(input logic [5:0] alive);
    alive_count = alive;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n;
    int mv0;
    bit seen312;
    logic landed_at312;

    Reset = 1'b1; start = 1'b0; freeze = 1'b0; alive_count = 6'd10;
    tick(); tick();
    check_reset_values("rst");
    Reset = 1'b0;

    // 1: first step 12 frames after the start edge (period 12)
    start_wave(6'd10);
    check_val("start_state", 32'(o_dbg_state), 32'(S_MARCH));
    wait_move("first_move", 30, n);
    check_val("first_move_lat", n, 12);
    check_val("first_move_x", 32'(fleet_x), 104);
    check_val("first_move_dirx", 32'(enemy_direction_X), 1);

    // 2: right edge at x=332 -> no step, 8 descent frames, y 40->48, turn left
    wait_x("right_run", 10'd332, 2000);
    mv0 = mv_cnt;
    wait_state("right_desc", S_DESCEND, 30, n);
    check_val("right_edge_lat", n, 12);
    check_val("right_edge_nomove", mv_cnt - mv0, 0);
    check_val("right_edge_x", 32'(fleet_x), 332);
    dy_cnt = 0;
    for (int i = 0; i < 12; i++) tick();
    check_val("right_diry_frames", dy_cnt, 8);
    check_val("right_drop_y", 32'(fleet_y), 48);
    check_val("right_drop_dirx", 32'(enemy_direction_X), 0);
    check_val("right_drop_state", 32'(o_dbg_state), 32'(S_MARCH));

    // 3: run left (period 3) to x=8, next tick descends, then turn right
    alive_count = 6'd1;
    wait_x("left_run", 10'd8, 1000);
    wait_state("left_desc", S_DESCEND, 10, n);
    check_val("left_edge_x", 32'(fleet_x), 8);
    wait_state("left_march", S_MARCH, 20, n);
    check_val("left_drop_dirx", 32'(enemy_direction_X), 1);
    check_val("left_drop_y", 32'(fleet_y), 56);

    // 4: keep bouncing until landing at y=320
    seen312 = 0;
    landed_at312 = 1'b1;
    for (int i = 0; i < 20000 && !fleet_landed; i++) begin
      tick();
      if (fleet_y == 10'd312 && !seen312) begin
        seen312 = 1;
        landed_at312 = fleet_landed;
      end
    end
    check_val("landed_flag", 32'(fleet_landed), 1);
    check_val("landed_not_at312", 32'(landed_at312), 0);
    check_val("landed_y", 32'(fleet_y), 320);
    check_val("landed_state", 32'(o_dbg_state), 32'(S_LANDED));
    mv_cnt = 0; dy_cnt = 0; wc_cnt = 0;
    start = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    start = 1'b0;
    check_val("landed_strobes", mv_cnt + dy_cnt + wc_cnt, 0);
    check_val("landed_hold_state", 32'(o_dbg_state), 32'(S_LANDED));
    check_val("landed_hold_y", 32'(fleet_y), 320);

    // freeze mid-march: hold position and frame count
    Reset = 1'b1; tick(); Reset = 1'b0;
    check_reset_values("rst2");
    start_wave(6'd10);
    for (int i = 0; i < 5; i++) tick();
    freeze = 1'b1;
    mv_cnt = 0;
    for (int i = 0; i < 7; i++) tick();
    check_val("freeze_nomove", mv_cnt, 0);
    check_val("freeze_x", 32'(fleet_x), 100);
    freeze = 1'b0;
    wait_move("unfreeze_move", 30, n);
    check_val("unfreeze_lat", n, 7);
    check_val("unfreeze_x", 32'(fleet_x), 104);

    // 5: alive 0 under freeze -> no pulse; released -> one pulse, IDLE
    for (int i = 0; i < 3; i++) tick();
    alive_count = 6'd0;
    freeze = 1'b1;
    tick();
    check_val("wclr_frozen", 32'(wave_clear), 0);
    check_val("wclr_frozen_state", 32'(o_dbg_state), 32'(S_MARCH));
    freeze = 1'b0;
    tick();
    check_val("wclr_pulse", 32'(wave_clear), 1);
    check_val("wclr_state", 32'(o_dbg_state), 32'(S_IDLE));
    check_val("wclr_nomove", 32'(move_en), 0);
    tick();
    check_val("wclr_one_frame", 32'(wave_clear), 0);

    // 6: Reset mid-descent, then scenario 1 again
    start_wave(6'd1);
    wait_state("rst_desc", S_DESCEND, 400, n);
    tick(); tick(); tick();
    check_val("mid_desc_diry", 32'(enemy_direction_Y), 1);
    Reset = 1'b1;
    tick();
    check_reset_values("rst3");
    Reset = 1'b0;
    start_wave(6'd10);
    wait_move("rerun_move", 30, n);
    check_val("rerun_lat", n, 12);
    check_val("rerun_x", 32'(fleet_x), 104);
    check_val("rerun_y", 32'(fleet_y), 40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
